// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one 16-bit Fibonacci LFSR; each grant returns WORD_WIDTH random bits.
// Grant arrives CHUNKS+1 cycles after the request is seen in IDLE; req is held, seed waits for seed_ready.
module rng_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  rand_valid,
  output logic [WORD_WIDTH-1:0] rand_data,
  output logic                  busy,
  input  logic                  seed_valid,
  input  logic [15:0]           seed_data,
  output logic                  seed_ready
);

  localparam int          CHUNKS    = WORD_WIDTH / 16;
  localparam int          IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [1:0] {IDLE, GATHER, DELIVER} state_t;

  state_t                state, state_nxt;
  logic [15:0]           lfsr, lfsr_step;
  logic [IW-1:0]         rr_ptr, idx, pick, k;
  logic [2:0]            cnt;
  logic                  found, last_chunk;
  logic [WORD_WIDTH-1:0] word_nxt;

  assign lfsr_step  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign last_chunk = (cnt == 3'(CHUNKS - 1));
  assign busy       = (state != IDLE);
  assign seed_ready = (state == IDLE);

  // Earlier chunks live in hist; the newest chunk always lands in the low 16 bits.
  if (CHUNKS > 1) begin : g_hist
    logic [WORD_WIDTH-17:0] hist;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)               hist <= '0;
      else if (state == GATHER) hist <= word_nxt[WORD_WIDTH-17:0];
    end
    assign word_nxt = {hist, lfsr_step};
  end else begin : g_nohist
    assign word_nxt = lfsr_step;
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[k]) begin
        found = 1'b1;
        pick  = k;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!seed_valid && found) state_nxt = GATHER;
      GATHER:  if (last_chunk) state_nxt = DELIVER;
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr       <= LFSR_INIT;
      rr_ptr     <= '0;
      idx        <= '0;
      cnt        <= '0;
      gnt        <= '0;
      rand_valid <= 1'b0;
      rand_data  <= '0;
    end else begin
      gnt        <= '0;
      rand_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // A zero seed would lock the LFSR, so it falls back to the reset value.
          if (seed_valid) begin
            lfsr <= (seed_data == 16'h0000) ? LFSR_INIT : seed_data;
          end else if (found) begin
            idx <= pick;
            cnt <= '0;
          end
        end
        GATHER: begin
          lfsr <= lfsr_step;
          cnt  <= cnt + 3'd1;
          if (last_chunk) begin
            gnt        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
            rand_valid <= 1'b1;
            rand_data  <= word_nxt;
          end
        end
        DELIVER: rr_ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: directed requests, expected grants queued and checked by a monitor.
module tb_rng_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        rand_valid;
  logic [31:0] rand_data;
  logic        busy;
  logic        seed_valid;
  logic [15:0] seed_data;
  logic        seed_ready;

  typedef struct packed {
    logic [3:0]  g;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] m_lfsr;
  logic [31:0] w;

  rng_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .gnt(gnt),
    .rand_valid(rand_valid), .rand_data(rand_data), .busy(busy),
    .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic gen_word(output logic [31:0] wd);
    logic [15:0] a, b;
    a = step(m_lfsr);
    b = step(a);
    m_lfsr = b;
    wd = {a, b};
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input logic [3:0] g, input logic [31:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(input string name, input logic [3:0] expg);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (gnt == 4'b0 && n < 20);
    if (gnt == 4'b0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for gnt actual=0 expected=%b", name, expg);
    end else begin
      chk(name, 64'(gnt), 64'(expg));
    end
  endtask

  always @(negedge clock) begin
    if (!reset && (rand_valid || gnt != 4'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant gnt=%b rand_valid=%b data=%h expected none", gnt, rand_valid, rand_data);
      end else begin
        e_mon = exp_q.pop_front();
        chk("mon_valid", 64'(rand_valid), 64'(1));
        chk("mon_gnt", 64'(gnt), 64'(e_mon.g));
        chk("mon_data", 64'(rand_data), 64'(e_mon.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc, last, got, n;
    reset = 1'b1; req = 4'b0; seed_valid = 1'b0; seed_data = 16'h0; m_lfsr = 16'hACE1;
    repeat (2) @(negedge clock);
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_valid", 64'(rand_valid), 0);
    chk("rst_data", 64'(rand_data), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_seed_ready", 64'(seed_ready), 1);
    reset = 1'b0;
    @(negedge clock);

    // Single request: latency, busy window and the known first word.
    expect_txn(4'b0001, 32'h5670AB38);
    gen_word(w);
    req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      chk("t1_busy", 64'(busy), (c <= 3) ? 64'(1) : 64'(0));
      chk("t1_gnt", 64'(gnt), (c == 3) ? 64'(1) : 64'(0));
      if (c == 3) req = 4'b0;
    end

    // All four requesting: round-robin order and fixed spacing.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_lfsr = 16'hACE1;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      gen_word(w);
      expect_txn(4'b0001 << (i % 4), w);
    end
    req = 4'b1111; cyc = 0; last = 0; got = 0;
    while (got < 8 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (gnt != 4'b0) begin
        chk("t2_onehot", 64'($onehot(gnt)), 1);
        if (got > 0) chk("t2_spacing", 64'(cyc - last), 4);
        last = cyc;
        got++;
        if (got == 8) req = 4'b0;
      end
    end
    if (got != 8) begin
      checks++; failures++;
      $display("FAIL t2_count actual=%0d expected=8", got);
    end
    @(negedge clock);

    // Zero seed falls back to ACE1.
    chk("t3_seed_ready", 64'(seed_ready), 1);
    seed_valid = 1'b1; seed_data = 16'h0000;
    @(negedge clock);
    seed_valid = 1'b0;
    m_lfsr = 16'hACE1;
    expect_txn(4'b0100, 32'h5670AB38);
    gen_word(w);
    req = 4'b0100;
    wait_gnt("t3a_gnt", 4'b0100);
    req = 4'b0;
    @(negedge clock);

    seed_valid = 1'b1; seed_data = 16'h5670;
    @(negedge clock);
    seed_valid = 1'b0;
    m_lfsr = 16'h5670;
    expect_txn(4'b0100, 32'hAB38559C);
    gen_word(w);
    chk("t3b_model_low", 64'(w[15:0]), 64'(step(16'hAB38)));
    req = 4'b0100;
    wait_gnt("t3b_gnt", 4'b0100);
    req = 4'b0;
    @(negedge clock);

    // Seed strobe during a transaction is ignored.
    gen_word(w);
    expect_txn(4'b0001, w);
    req = 4'b0001;
    @(negedge clock);
    chk("t4_seed_ready_g1", 64'(seed_ready), 0);
    seed_valid = 1'b1; seed_data = 16'h1234;
    @(negedge clock);
    chk("t4_seed_ready_g2", 64'(seed_ready), 0);
    @(negedge clock);
    chk("t4_seed_ready_dl", 64'(seed_ready), 0);
    chk("t4_gnt", 64'(gnt), 64'(4'b0001));
    seed_valid = 1'b0; req = 4'b0;
    @(negedge clock);
    chk("t4_seed_ready_idle", 64'(seed_ready), 1);

    // Seed and request together: seed loads first, grant uses it.
    seed_valid = 1'b1; seed_data = 16'h5670; req = 4'b0010;
    m_lfsr = 16'h5670;
    gen_word(w);
    expect_txn(4'b0010, w);
    @(negedge clock);
    seed_valid = 1'b0;
    chk("t4b_still_idle", 64'(busy), 0);
    wait_gnt("t4b_gnt", 4'b0010);
    req = 4'b0;
    @(negedge clock);

    // Reset in the second GATHER cycle aborts without a grant.
    req = 4'b0001;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("t5_gnt", 64'(gnt), 0);
    chk("t5_valid", 64'(rand_valid), 0);
    chk("t5_data", 64'(rand_data), 0);
    chk("t5_busy", 64'(busy), 0);
    req = 4'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_lfsr = 16'hACE1;
    @(negedge clock);
    expect_txn(4'b0001, 32'h5670AB38);
    gen_word(w);
    req = 4'b0001;
    wait_gnt("t5_regrant", 4'b0001);
    req = 4'b0;
    @(negedge clock);

    // Requester 1 drops mid-transaction; pointer still advances and wraps.
    gen_word(w);
    expect_txn(4'b0010, w);
    req = 4'b0010;
    @(negedge clock);
    req = 4'b0;
    wait_gnt("t6_dropped_gnt", 4'b0010);
    @(negedge clock);
    gen_word(w);
    expect_txn(4'b0001, w);
    req = 4'b0011;
    wait_gnt("t6_wrap_gnt", 4'b0001);
    req = 4'b0;

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("queue_drained", 64'(exp_q.size()), 0);
    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
